// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: NCH-channel valid/ready arbiter onto one shared memory port with in-order response routing.
// Build option MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins); default is round-robin.
module mem_port_arbiter #(
   parameter int NCH    = 2,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int MAXOUT = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NCH-1:0]                ch_req_valid,
   output logic [NCH-1:0]                ch_req_ready,
   input  logic [NCH*AW-1:0]             ch_req_addr,
   input  logic [NCH*DW-1:0]             ch_req_data,
   input  logic [NCH-1:0]                ch_req_fcn,
   input  logic [NCH*3-1:0]              ch_req_typ,
   output logic [NCH-1:0]                ch_resp_valid,
   output logic [DW-1:0]                 ch_resp_data,
   output logic                          mem_req_valid,
   input  logic                          mem_req_ready,
   output logic [AW-1:0]                 mem_req_addr,
   output logic [DW-1:0]                 mem_req_data,
   output logic                          mem_req_fcn,
   output logic [2:0]                    mem_req_typ,
   input  logic                          mem_resp_valid,
   input  logic [DW-1:0]                 mem_resp_data,
   output logic [$clog2(MAXOUT+1)-1:0]   outstanding,
   output logic                          err_unexp_resp
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
   localparam int CW = $clog2(MAXOUT + 1);

   logic [IW-1:0] winner, grant, lock_id, head;
   logic          lock;
   logic [IW-1:0] id_mem [MAXOUT];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          fifo_full, fifo_empty, accept, pop, err_q;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAXOUT - 1)) ? '0 : p + PW'(1);
   endfunction

`ifdef MEM_ARB_FIXED_PRIO_EN
   always_comb begin
      winner = '0;
      for (int j = NCH - 1; j >= 0; j--)
         if (ch_req_valid[j]) winner = IW'(j);
   end
`else
   logic [IW-1:0] rr_ptr;

   // Scanning offsets high-to-low lets the smallest offset from rr_ptr overwrite the others.
   always_comb begin
      int idx;
      idx    = 0;
      winner = rr_ptr;
      for (int j = NCH - 1; j >= 0; j--) begin
         idx = int'(rr_ptr) + j;
         if (idx >= NCH) idx = idx - NCH;
         if (ch_req_valid[idx]) winner = IW'(idx);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (accept)
         rr_ptr <= (grant == IW'(NCH - 1)) ? '0 : grant + IW'(1);
   end
`endif

   assign grant         = lock ? lock_id : winner;
   assign fifo_full     = (count == CW'(MAXOUT));
   assign fifo_empty    = (count == '0);
   assign mem_req_valid = rst_n && (|ch_req_valid) && !fifo_full;
   assign accept        = mem_req_valid && mem_req_ready;
   assign head          = id_mem[rd_ptr];
   assign pop           = rst_n && mem_resp_valid && !fifo_empty;
   assign ch_resp_data  = mem_resp_data;
   assign outstanding   = count;
   assign err_unexp_resp = err_q;

   // NOTE: every output of a combinational block gets a default first; a missed path infers a latch.
   always_comb begin
      mem_req_addr  = '0;
      mem_req_data  = '0;
      mem_req_fcn   = 1'b0;
      mem_req_typ   = '0;
      ch_req_ready  = '0;
      ch_resp_valid = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant == IW'(i)) begin
            mem_req_addr    = ch_req_addr[i*AW +: AW];
            mem_req_data    = ch_req_data[i*DW +: DW];
            mem_req_fcn     = ch_req_fcn[i];
            mem_req_typ     = ch_req_typ[i*3 +: 3];
            ch_req_ready[i] = accept;
         end
         ch_resp_valid[i] = pop && (head == IW'(i));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock    <= 1'b0;
         lock_id <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (mem_req_valid && !mem_req_ready) begin
            lock    <= 1'b1;
            lock_id <= grant;
         end else if (accept) begin
            lock <= 1'b0;
         end
         if (accept) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)    rd_ptr <= ptr_inc(rd_ptr);
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (mem_resp_valid && fifo_empty) err_q <= 1'b1;
      end
   end

   // NOTE: ID storage is not reset; occupancy is tracked by count and pointers, which are.
   always_ff @(posedge clk) begin
      if (accept) id_mem[wr_ptr] <= grant;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a grant/response scoreboard for mem_port_arbiter.
// Grant expectations follow MEM_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_mem_port_arbiter;
   localparam int NCH = 2, AW = 32, DW = 32, MAXOUT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    ch_req_valid, ch_req_ready, ch_req_fcn, ch_resp_valid;
   logic [NCH*AW-1:0] ch_req_addr;
   logic [NCH*DW-1:0] ch_req_data;
   logic [NCH*3-1:0]  ch_req_typ;
   logic [DW-1:0]     ch_resp_data, mem_req_data, mem_resp_data;
   logic [AW-1:0]     mem_req_addr;
   logic              mem_req_valid, mem_req_ready, mem_req_fcn, mem_resp_valid, err_unexp_resp;
   logic [2:0]        mem_req_typ;
   logic [1:0]        outstanding;

   always #5 clk = ~clk;

   mem_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
      .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data),
      .ch_req_fcn(ch_req_fcn), .ch_req_typ(ch_req_typ),
      .ch_resp_valid(ch_resp_valid), .ch_resp_data(ch_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .outstanding(outstanding), .err_unexp_resp(err_unexp_resp)
   );

   typedef struct { logic [NCH-1:0] oh; logic [AW-1:0] addr; logic fcn; } gnt_t;
   typedef struct { logic [NCH-1:0] oh; logic [DW-1:0] data; } rsp_t;

   gnt_t gnt_q[$];
   rsp_t rsp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_gnt(input int ch, input logic [AW-1:0] addr, input logic fcn);
      gnt_t g;
      g.oh     = '0;
      g.oh[ch] = 1'b1;
      g.addr   = addr;
      g.fcn    = fcn;
      gnt_q.push_back(g);
   endtask

   task automatic exp_rsp(input int ch, input logic [DW-1:0] data);
      rsp_t r;
      r.oh     = '0;
      r.oh[ch] = 1'b1;
      r.data   = data;
      rsp_q.push_back(r);
   endtask

   task automatic set_ch(input int ch, input logic v, input logic [AW-1:0] addr, input logic fcn);
      ch_req_valid[ch]          = v;
      ch_req_addr[ch*AW +: AW]  = addr;
      ch_req_data[ch*DW +: DW]  = addr + 32'h5000;
      ch_req_fcn[ch]            = fcn;
      ch_req_typ[ch*3 +: 3]     = 3'd2;
   endtask

   task automatic resp(input logic v, input logic [DW-1:0] data);
      mem_resp_valid = v;
      mem_resp_data  = data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT grants or routes a response.
   initial begin
      gnt_t g;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (|ch_req_ready) begin
            if (gnt_q.size() == 0) begin
               check("gnt_unexpected", ch_req_ready, '0);
            end else begin
               g = gnt_q.pop_front();
               check("gnt_onehot", ch_req_ready, g.oh);
               check("gnt_addr", mem_req_addr, g.addr);
               check("gnt_fcn", mem_req_fcn, g.fcn);
            end
         end
         if (|ch_resp_valid) begin
            if (rsp_q.size() == 0) begin
               check("rsp_unexpected", ch_resp_valid, '0);
            end else begin
               r = rsp_q.pop_front();
               check("rsp_onehot", ch_resp_valid, r.oh);
               check("rsp_data", ch_resp_data, r.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      int seq[4] = '{0, 0, 0, 0};
`else
      int seq[4] = '{0, 1, 0, 1};
`endif

      // Reset with busy inputs: handshake outputs must stay low.
      rst_n = 1'b0;
      ch_req_valid = '0; ch_req_addr = '0; ch_req_data = '0; ch_req_fcn = '0; ch_req_typ = '0;
      set_ch(0, 1'b1, 32'h0, 1'b0);
      set_ch(1, 1'b1, 32'h4, 1'b0);
      mem_req_ready = 1'b1;
      resp(1'b1, 32'h1234);
      step();
      #2;
      check("rst_mem_req_valid", mem_req_valid, 0);
      check("rst_ch_req_ready", ch_req_ready, 0);
      check("rst_ch_resp_valid", ch_resp_valid, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_err", err_unexp_resp, 0);
      set_ch(0, 1'b0, 32'h0, 1'b0);
      set_ch(1, 1'b0, 32'h0, 1'b0);
      resp(1'b0, '0);
      step();
      rst_n = 1'b1;

      // 1: single ch0 load and its response.
      set_ch(0, 1'b1, 32'h100, 1'b0);
      exp_gnt(0, 32'h100, 1'b0);
      #2;
      check("t1_ready", ch_req_ready, 2'b01);
      check("t1_outstanding0", outstanding, 0);
      step();
      set_ch(0, 1'b0, 32'h100, 1'b0);
      resp(1'b1, 32'hDEADBEEF);
      exp_rsp(0, 32'hDEADBEEF);
      #2;
      check("t1_outstanding1", outstanding, 1);
      step();
      resp(1'b0, '0);
      #2;
      check("t1_outstanding_end", outstanding, 0);

      // 2: both channels always valid, immediate responses.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         if (c < 4) begin
            set_ch(0, 1'b1, 32'h200, 1'b0);
            set_ch(1, 1'b1, 32'h300, 1'b0);
            exp_gnt(seq[c], (seq[c] == 1) ? 32'h300 : 32'h200, 1'b0);
         end else begin
            set_ch(0, 1'b0, 32'h200, 1'b0);
            set_ch(1, 1'b0, 32'h300, 1'b0);
         end
         if (c > 0) begin
            resp(1'b1, 32'h1000 + c);
            exp_rsp(seq[c-1], 32'h1000 + c);
         end
         step();
      end
      resp(1'b0, '0);
      #2;
      check("t2_outstanding_end", outstanding, 0);

      // 3: ch1 stalled by mem_req_ready=0, ch0 arrives mid-stall; grant must stay locked.
      set_ch(1, 1'b1, 32'h444, 1'b1);
      mem_req_ready = 1'b0;
      #2;
      check("t3_valid", mem_req_valid, 1);
      check("t3_addr_c0", mem_req_addr, 32'h444);
      step();
      #2;
      check("t3_addr_c1", mem_req_addr, 32'h444);
      step();
      set_ch(0, 1'b1, 32'h555, 1'b0);
      #2;
      check("t3_lock_addr", mem_req_addr, 32'h444);
      check("t3_no_ready", ch_req_ready, 0);
      step();
      mem_req_ready = 1'b1;
      exp_gnt(1, 32'h444, 1'b1);
      step();
      set_ch(1, 1'b0, 32'h444, 1'b1);
      exp_gnt(0, 32'h555, 1'b0);
      step();
      set_ch(0, 1'b0, 32'h555, 1'b0);
      resp(1'b1, 32'hA1);
      exp_rsp(1, 32'hA1);
      #2;
      check("t3_outstanding2", outstanding, 2);
      step();
      resp(1'b1, 32'hA0);
      exp_rsp(0, 32'hA0);
      step();
      resp(1'b0, '0);
      #2;
      check("t3_outstanding_end", outstanding, 0);

      // 4: third back-to-back request stalls on a full ID FIFO, even across a pop.
      set_ch(0, 1'b1, 32'h10, 1'b0);
      exp_gnt(0, 32'h10, 1'b0);
      step();
      set_ch(0, 1'b1, 32'h20, 1'b0);
      exp_gnt(0, 32'h20, 1'b0);
      step();
      set_ch(0, 1'b1, 32'h30, 1'b0);
      #2;
      check("t4_full_stall", mem_req_valid, 0);
      check("t4_outstanding_full", outstanding, 2);
      step();
      resp(1'b1, 32'hB0);
      exp_rsp(0, 32'hB0);
      #2;
      check("t4_pop_no_bypass", mem_req_valid, 0);
      step();
      resp(1'b0, '0);
      exp_gnt(0, 32'h30, 1'b0);
      #2;
      check("t4_third_issues", mem_req_valid, 1);
      check("t4_outstanding1", outstanding, 1);
      step();
      set_ch(0, 1'b0, 32'h30, 1'b0);
      resp(1'b1, 32'hB1);
      exp_rsp(0, 32'hB1);
      step();
      resp(1'b1, 32'hB2);
      exp_rsp(0, 32'hB2);
      step();
      resp(1'b0, '0);
      #2;
      check("t4_outstanding_end", outstanding, 0);

      // 5: in-order routing of responses to the issuing channel.
      set_ch(0, 1'b1, 32'h50, 1'b0);
      exp_gnt(0, 32'h50, 1'b0);
      step();
      set_ch(0, 1'b0, 32'h50, 1'b0);
      set_ch(1, 1'b1, 32'h60, 1'b1);
      exp_gnt(1, 32'h60, 1'b1);
      step();
      set_ch(1, 1'b0, 32'h60, 1'b1);
      resp(1'b1, 32'hA);
      exp_rsp(0, 32'hA);
      step();
      resp(1'b1, 32'hB);
      exp_rsp(1, 32'hB);
      step();
      resp(1'b0, '0);

      // 6: unexpected response sets a sticky error cleared only by reset.
      #2;
      check("t6_outstanding0", outstanding, 0);
      resp(1'b1, 32'h77);
      #1;
      check("t6_no_route", ch_resp_valid, 0);
      check("t6_err_before_edge", err_unexp_resp, 0);
      step();
      resp(1'b0, '0);
      #2;
      check("t6_err_set", err_unexp_resp, 1);
      step();
      step();
      check("t6_err_held", err_unexp_resp, 1);
      do_reset();
      #2;
      check("t6_err_cleared", err_unexp_resp, 0);

      // Reset mid-transaction drops the outstanding ID; the late response is unexpected.
      set_ch(0, 1'b1, 32'h90, 1'b0);
      exp_gnt(0, 32'h90, 1'b0);
      step();
      set_ch(0, 1'b0, 32'h90, 1'b0);
      do_reset();
      #2;
      check("t7_outstanding_cleared", outstanding, 0);
      resp(1'b1, 32'h99);
      step();
      resp(1'b0, '0);
      #2;
      check("t7_err_late_resp", err_unexp_resp, 1);

      step();
      step();
      check("gnt_queue_drained", gnt_q.size(), 0);
      check("rsp_queue_drained", rsp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
